// File: rtl/fwd_hazard_tracker.sv
// Forwarding and hazard tracker: follows in-flight register writers after EX,
// selects forward sources per operand, and raises stalls for load-use and multicycle ops.
module fwd_hazard_tracker #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int MD_LAT  = 4,
  parameter int SEL_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  input  logic                       ex_reg_write,
  input  logic [ADDR_W-1:0]          ex_dest,
  input  logic                       ex_is_load,
  input  logic                       ex_is_md,
  input  logic [NUM_SRC*ADDR_W-1:0]  ex_src,
  input  logic                       dec_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]  dec_src,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic                       md_busy,
  output logic [15:0]                stall_cnt
);

  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  regWrite_q;
  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [MD_W-1:0]   mdCnt_q, mdCnt_d;
  logic [15:0]       stallCnt_q, stallCnt_d;
  logic              exLive;
  logic              mdIssue;
  logic              loadUse;

  assign exLive  = ex_valid & ~flush;
  assign mdIssue = exLive & ex_is_md;

  // Only the valid bits need clearing; payload of an invalid entry is never matched.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      mdCnt_q    <= '0;
      stallCnt_q <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        valid_q[k] <= valid_q[k-1];
      end
      valid_q[0] <= exLive;
      mdCnt_q    <= mdCnt_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = DEPTH - 1; k >= 1; k--) begin
      regWrite_q[k] <= regWrite_q[k-1];
      dest_q[k]     <= dest_q[k-1];
    end
    regWrite_q[0] <= ex_reg_write;
    dest_q[0]     <= ex_dest;
  end

  // A fresh multicycle issue reloads the full occupancy rather than extending it.
  always_comb begin
    mdCnt_d = mdCnt_q;
    if (mdIssue) begin
      mdCnt_d = MD_W'(MD_LAT - 1);
    end else if (mdCnt_q != '0) begin
      mdCnt_d = mdCnt_q - MD_W'(1);
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && regWrite_q[k] && (ex_src[i*ADDR_W +: ADDR_W] != '0) &&
            (dest_q[k] == ex_src[i*ADDR_W +: ADDR_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    loadUse = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (exLive && ex_is_load && ex_reg_write && (ex_dest != '0) && dec_valid &&
          (dec_src[i*ADDR_W +: ADDR_W] == ex_dest)) begin
        loadUse = 1'b1;
      end
    end
  end

  assign md_busy   = (mdCnt_q != '0);
  assign stall     = loadUse | (md_busy & dec_valid);
  assign stall_cnt = stallCnt_q;

endmodule

// File: doc/fwd_hazard_tracker.md
FWD_HAZARD_TRACKER -- requirements
Module: fwd_hazard_tracker

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- ADDR_W, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 3, forwardable in-flight stages after EX (1..7).
- MD_LAT, 4, multicycle (mult/div) occupancy in cycles (>=1).
- SEL_W, 3, width of each forward select (>= clog2(DEPTH+1)).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous, active-high reset.
- ex_valid, in, 1, EX stage holds a real instruction.
- ex_reg_write, in, 1, EX instruction writes a register.
- ex_dest, in, ADDR_W, EX destination register.
- ex_is_load, in, 1, EX instruction is a load.
- ex_is_md, in, 1, EX instruction is a multicycle op.
- ex_src, in, NUM_SRC*ADDR_W, EX source registers; operand i in bits [i*ADDR_W +: ADDR_W].
- dec_valid, in, 1, ID stage holds a real instruction.
- dec_src, in, NUM_SRC*ADDR_W, ID source registers, same packing as ex_src.
- flush, in, 1, kill the EX instruction this cycle.
- fwd_sel, out, NUM_SRC*SEL_W, per-operand forward select; 0 = register file, k = tracker entry k-1.
- stall, out, 1, hold PC and IF/ID and insert an EX bubble.
- md_busy, out, 1, multicycle unit occupied.
- stall_cnt, out, 16, saturating count of stalled cycles.

Function
REQ-003 The tracker SHALL hold DEPTH entries {valid, reg_write, dest, is_load}: entry 0 = EX/MEM, entry DEPTH-1 = oldest.
REQ-004 Each clock, entry k SHALL take entry k-1 for k >= 1.
REQ-005 Each clock, entry 0 SHALL capture ex_* with valid = ex_valid & !flush; a killed instruction enters as invalid.
REQ-006 An entry SHALL be a match for register r when valid & reg_write & dest == r & r != 0.
REQ-007 fwd_sel for operand i SHALL be combinational: k+1 for the lowest-index (youngest) entry k matching ex_src[i], else 0.
REQ-008 Source register 0 SHALL always yield fwd_sel 0.
REQ-009 load_use SHALL be asserted when ex_valid & !flush & ex_is_load & ex_reg_write & ex_dest != 0 & dec_valid, and any dec_src operand equals ex_dest.
REQ-010 The multicycle counter md_cnt SHALL load MD_LAT-1 on ex_valid & ex_is_md & !flush.
REQ-011 Otherwise md_cnt SHALL decrement when non-zero and hold at 0.
REQ-012 A new multicycle issue while md_cnt != 0 SHALL reload md_cnt, not add to it.
REQ-013 md_busy SHALL equal (md_cnt != 0).
REQ-014 stall SHALL equal load_use | (md_busy & dec_valid), combinationally, with zero added latency.
REQ-015 stall SHALL not gate tracker shifting; the pipeline inserts the bubble by driving ex_valid=0 in the following cycle.
REQ-016 stall_cnt SHALL increment by 1 on every clock with stall=1 and saturate at 16'hFFFF.
REQ-017 flush and stall in the same cycle SHALL be legal: flush kills the EX capture and suppresses load_use and any md load from that instruction.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL clear all entry valid bits, md_cnt and stall_cnt to 0.
REQ-019 Immediately after reset, fwd_sel, md_busy and stall_cnt SHALL be 0.
REQ-020 Immediately after reset, stall SHALL be 0 unless load_use is asserted from the inputs.
REQ-021 rst SHALL take priority over every other input on the same edge, including mid-multicycle; forwarding state is discarded.

Verification
REQ-022 A bench with DEPTH=3 and MD_LAT=4 SHALL cover these scenarios:
- Back-to-back ALU: cycle 0 EX writes r5; cycle 1 ex_src[0]=5 -> fwd_sel[0]=1.
- Same r5 with cycles 1-2 bubbles; cycle 3 ex_src[0]=5 -> fwd_sel[0]=3; cycle 4 -> 0.
- Two writes to r7 in consecutive cycles, then a reader of r7 -> fwd_sel=1 (youngest wins).
- Source r0 with a valid write to r0 in flight -> fwd_sel=0.
- Load to r9 in EX with dec_src[1]=9 -> stall=1 that cycle only; stall_cnt 0 -> 1.
- Same load with flush=1 -> stall=0.
- Multicycle issue at cycle 0 with dec_valid held 1 -> md_busy=1 and stall=1 for cycles 1-3, both 0 at cycle 4.
- rst asserted at cycle 2 of that sequence -> md_busy=0 next cycle.
- stall held 1 for 70000 cycles -> stall_cnt=16'hFFFF and it holds there.
